// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: launches and supervises one processor run.
//   IDLE -> RST_CORE (core held in reset for RST_CYCLES) -> RUN -> DONE | TMO
// A run ends as DONE when the PC stays unchanged for HALT_REPEAT consecutive
// RUN cycles (or reaches END_PC when END_PC_EN=1). It ends as TMO when
// MAX_CYCLES RUN cycles pass without a halt. abort returns to IDLE.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start/clear/abort  level-sampled control requests
//   pc                 processor instruction address
//   core_reset         reset to the processor (IDLE, RST_CORE)
//   running/done/timeout  state flags RUN / DONE / TMO
//   cycle_count        RUN cycles completed in the current/last run
//   halt_pc            PC captured in the terminating cycle
// All outputs come straight from flops.
module proc_run_ctrl #(
  parameter int ADDR_W      = 64,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 4,
  parameter int MAX_CYCLES  = 1000,
  parameter int HALT_REPEAT = 3,
  parameter int END_PC_EN   = 0,
  parameter logic [ADDR_W-1:0] END_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pc,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W-1:0] halt_pc
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int HW = $clog2(HALT_REPEAT + 1);

  typedef enum logic [2:0] {IDLE, RST_CORE, RUN, DONE, TMO} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d, cyc_inc;
  logic [ADDR_W-1:0] hpc_q, hpc_d, prev_q, prev_d;
  logic [HW-1:0]     rep_q, rep_d, rep_nx;
  logic              new_pc, halt, budget;
  logic              core_reset_q, running_q, done_q, timeout_q;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cyc_d   = cyc_q;
    hpc_d   = hpc_q;
    prev_d  = prev_q;
    rep_d   = rep_q;

    // Saturating increment; the budget check stops RUN long before wrap.
    cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
    // rep_q==0 marks the first RUN cycle: pc_prev is not valid yet.
    new_pc  = (rep_q == '0) || (pc != prev_q);
    if (new_pc)                         rep_nx = HW'(1);
    else if (rep_q == HW'(HALT_REPEAT)) rep_nx = rep_q;
    else                                rep_nx = rep_q + 1'b1;
    halt    = (rep_nx == HW'(HALT_REPEAT)) || ((END_PC_EN != 0) && (pc == END_PC));
    budget  = (cyc_inc == CNT_W'(MAX_CYCLES));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RST_CORE;
          rcnt_d  = RW'(RST_CYCLES);
          cyc_d   = '0;
          hpc_d   = '0;
          prev_d  = '0;
          rep_d   = '0;
        end
      end
      RST_CORE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rcnt_q <= RW'(1)) begin
          state_d = RUN;
          rcnt_d  = '0;
        end else begin
          rcnt_d  = rcnt_q - 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cyc_d  = cyc_inc;
          rep_d  = rep_nx;
          if (new_pc) prev_d = pc;
          // halt outranks budget when both land on the same cycle
          if (halt) begin
            state_d = DONE;
            hpc_d   = pc;
          end else if (budget) begin
            state_d = TMO;
            hpc_d   = pc;
          end
        end
      end
      DONE, TMO: begin
        if (clear) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RST_CORE;
          rcnt_d  = RW'(RST_CYCLES);
          cyc_d   = '0;
          hpc_d   = '0;
          prev_d  = '0;
          rep_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rcnt_q       <= '0;
      cyc_q        <= '0;
      hpc_q        <= '0;
      prev_q       <= '0;
      rep_q        <= '0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      cyc_q        <= cyc_d;
      hpc_q        <= hpc_d;
      prev_q       <= prev_d;
      rep_q        <= rep_d;
      // flags are registered from the next state so they track state_q exactly
      core_reset_q <= (state_d == IDLE) || (state_d == RST_CORE);
      running_q    <= (state_d == RUN);
      done_q       <= (state_d == DONE);
      timeout_q    <= (state_d == TMO);
    end
  end

  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cyc_q;
  assign halt_pc     = hpc_q;
endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: three instances (defaults, MAX_CYCLES=16,
// END_PC enabled). Each run's expected ending is queued before the run; a
// monitor pops and compares whenever an instance leaves RUN.
module tb_proc_run_ctrl;
  typedef struct packed {
    logic        d;
    logic        t;
    logic        cr;
    logic [31:0] cnt;
    logic [63:0] hpc;
  } exp_t;

  logic        clk;
  logic        reset_w [3];
  logic        start_w [3];
  logic        clear_w [3];
  logic        abort_w [3];
  logic [63:0] pc_w    [3];
  logic        cr_w    [3];
  logic        run_w   [3];
  logic        done_w  [3];
  logic        tmo_w   [3];
  logic [31:0] cnt_w   [3];
  logic [63:0] hpc_w   [3];

  exp_t        sbq [3][$];
  logic [63:0] pcs [0:31];
  logic        run_prev [3] = '{1'b0, 1'b0, 1'b0};
  int          total = 0;
  int          bad   = 0;

  proc_run_ctrl u0 (
    .clk(clk), .reset(reset_w[0]), .start(start_w[0]), .clear(clear_w[0]),
    .abort(abort_w[0]), .pc(pc_w[0]), .core_reset(cr_w[0]), .running(run_w[0]),
    .done(done_w[0]), .timeout(tmo_w[0]), .cycle_count(cnt_w[0]), .halt_pc(hpc_w[0]));

  proc_run_ctrl #(.MAX_CYCLES(16)) u1 (
    .clk(clk), .reset(reset_w[1]), .start(start_w[1]), .clear(clear_w[1]),
    .abort(abort_w[1]), .pc(pc_w[1]), .core_reset(cr_w[1]), .running(run_w[1]),
    .done(done_w[1]), .timeout(tmo_w[1]), .cycle_count(cnt_w[1]), .halt_pc(hpc_w[1]));

  proc_run_ctrl #(.END_PC_EN(1), .END_PC(64'h20)) u2 (
    .clk(clk), .reset(reset_w[2]), .start(start_w[2]), .clear(clear_w[2]),
    .abort(abort_w[2]), .pc(pc_w[2]), .core_reset(cr_w[2]), .running(run_w[2]),
    .done(done_w[2]), .timeout(tmo_w[2]), .cycle_count(cnt_w[2]), .halt_pc(hpc_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a run has ended whenever running drops.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (run_prev[i] && !run_w[i]) begin
        if (sbq[i].size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: inst %0d left RUN with nothing queued", i);
        end else begin
          exp_t e;
          e = sbq[i].pop_front();
          chk($sformatf("sb%0d_done", i),  64'(done_w[i]), 64'(e.d));
          chk($sformatf("sb%0d_tmo", i),   64'(tmo_w[i]),  64'(e.t));
          chk($sformatf("sb%0d_creset", i), 64'(cr_w[i]),  64'(e.cr));
          chk($sformatf("sb%0d_cnt", i),   64'(cnt_w[i]),  64'(e.cnt));
          chk($sformatf("sb%0d_hpc", i),   hpc_w[i],       e.hpc);
        end
      end
      run_prev[i] = run_w[i];
    end
  end

  function automatic exp_t mk(input logic d, input logic t, input logic cr,
                              input int cnt, input logic [63:0] hpc);
    exp_t e;
    e.d = d; e.t = t; e.cr = cr; e.cnt = 32'(cnt); e.hpc = hpc;
    return e;
  endfunction

  // start held for 'hold' edges; RUN must appear 5 edges after the start edge
  task automatic launch(input int i, input bit detail, input int hold);
    start_w[i] = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step();
      if (e + 1 >= hold) start_w[i] = 1'b0;
      if (e == 0) chk("launch_cnt_clear", 64'(cnt_w[i]), 64'd0);
      if (detail) begin
        chk($sformatf("rst_core_creset_%0d", e), 64'(cr_w[i]), 64'd1);
        chk($sformatf("rst_core_running_%0d", e), 64'(run_w[i]), 64'd0);
      end
    end
    step();
    chk("run_entry_running", 64'(run_w[i]), 64'd1);
    chk("run_entry_creset", 64'(cr_w[i]), 64'd0);
  endtask

  task automatic run_pcs(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      pc_w[i] = pcs[k];
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      reset_w[i] = 1'b1; start_w[i] = 1'b1; clear_w[i] = 1'b0;
      abort_w[i] = 1'b0; pc_w[i] = '0;
    end
    step(); step();
    // reset wins over a simultaneous start
    for (int i = 0; i < 3; i++) chk("rst_creset", 64'(cr_w[i]), 64'd1);
    chk("rst_running", 64'(run_w[0]), 64'd0);
    chk("rst_done", 64'(done_w[0]), 64'd0);
    chk("rst_tmo", 64'(tmo_w[0]), 64'd0);
    chk("rst_cnt", 64'(cnt_w[0]), 64'd0);
    chk("rst_hpc", hpc_w[0], 64'd0);
    for (int i = 0; i < 3; i++) begin reset_w[i] = 1'b0; start_w[i] = 1'b0; end
    step();
    chk("idle_after_rst", 64'(cr_w[0]), 64'd1);

    // repeat halt: pc 0,4,8,8,8 ; start held 3 edges launches one run
    sbq[0].push_back(mk(1'b1, 1'b0, 1'b0, 5, 64'd8));
    launch(0, 1'b1, 3);
    pcs[0] = 0; pcs[1] = 4; pcs[2] = 8; pcs[3] = 8; pcs[4] = 8;
    run_pcs(0, 5);
    step(); step(); step();
    chk("done_hold", 64'(done_w[0]), 64'd1);
    chk("done_cnt_hold", 64'(cnt_w[0]), 64'd5);
    chk("done_creset", 64'(cr_w[0]), 64'd0);

    // restart from DONE, then abort after 7 RUN cycles
    for (int k = 0; k < 32; k++) pcs[k] = 64'(4 * k);
    sbq[0].push_back(mk(1'b0, 1'b0, 1'b1, 7, 64'd0));
    launch(0, 1'b0, 1);
    run_pcs(0, 7);
    abort_w[0] = 1'b1;
    step();
    abort_w[0] = 1'b0;
    // abort in IDLE is ignored
    abort_w[0] = 1'b1; step(); abort_w[0] = 1'b0;
    chk("abort_idle_cnt", 64'(cnt_w[0]), 64'd7);

    // reset mid-run after 7 RUN cycles
    sbq[0].push_back(mk(1'b0, 1'b0, 1'b1, 0, 64'd0));
    launch(0, 1'b0, 1);
    run_pcs(0, 7);
    reset_w[0] = 1'b1;
    step();
    reset_w[0] = 1'b0;

    // budget with pc +4 each cycle
    sbq[1].push_back(mk(1'b0, 1'b1, 1'b0, 16, 64'd60));
    launch(1, 1'b0, 1);
    run_pcs(1, 16);
    step();
    chk("tmo_hold", 64'(tmo_w[1]), 64'd1);
    clear_w[1] = 1'b1;
    step();
    clear_w[1] = 1'b0;
    chk("clear_creset", 64'(cr_w[1]), 64'd1);
    chk("clear_tmo", 64'(tmo_w[1]), 64'd0);
    for (int k = 0; k < 6; k++) step();
    chk("clear_stays_idle", 64'(run_w[1]), 64'd0);

    // halt and budget on the same cycle: DONE wins
    for (int k = 0; k < 14; k++) pcs[k] = 64'(4 * k);
    pcs[14] = 64'd52; pcs[15] = 64'd52;
    sbq[1].push_back(mk(1'b1, 1'b0, 1'b0, 16, 64'd52));
    launch(1, 1'b0, 1);
    run_pcs(1, 16);

    // end-address halt, then start+clear together -> IDLE
    for (int k = 0; k < 32; k++) pcs[k] = 64'(4 * k);
    sbq[2].push_back(mk(1'b1, 1'b0, 1'b0, 9, 64'h20));
    launch(2, 1'b0, 1);
    run_pcs(2, 9);
    step();
    start_w[2] = 1'b1; clear_w[2] = 1'b1;
    step();
    start_w[2] = 1'b0; clear_w[2] = 1'b0;
    chk("sc_done", 64'(done_w[2]), 64'd0);
    chk("sc_creset", 64'(cr_w[2]), 64'd1);
    for (int k = 0; k < 6; k++) step();
    chk("sc_no_launch", 64'(run_w[2]), 64'd0);

    step(); step();
    for (int i = 0; i < 3; i++)
      chk($sformatf("sb%0d_drained", i), 64'(sbq[i].size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/proc_run_ctrl.md
PROC_RUN_CTRL -- requirements
Module: proc_run_ctrl

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 64, PC width.
- CNT_W, 32, cycle counter width.
- RST_CYCLES, 4, core reset pulse length (>=1).
- MAX_CYCLES, 1000, RUN cycle budget (>=2).
- HALT_REPEAT, 3, consecutive identical PC samples meaning halt (>=2).
- END_PC_EN, 0, 1 enables end-address halt.
- END_PC, 0, end address.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high block reset.
- start  in  1  launch request.
- clear  in  1  return to IDLE.
- abort  in  1  cancel current run.
- pc  in  ADDR_W  processor Instruction_Address.
- core_reset  out  1  reset driven to processor.
- running  out  1  RUN state.
- done  out  1  halt detected.
- timeout  out  1  budget exhausted.
- cycle_count  out  CNT_W  RUN cycles completed.
- halt_pc  out  ADDR_W  PC captured at termination.
REQ-003 The clock SHALL be named clk and the reset SHALL be named reset; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, RST_CORE, RUN, DONE, TMO, all registered; every output SHALL be driven from registers.
REQ-005 core_reset SHALL be 1 in IDLE and RST_CORE and 0 otherwise.
REQ-006 running SHALL equal (state==RUN), done SHALL equal (state==DONE), and timeout SHALL equal (state==TMO).
REQ-007 IDLE: start=1 SHALL move the FSM to RST_CORE, clear cycle_count and halt_pc, and load the reset counter with RST_CYCLES.
REQ-008 RST_CORE SHALL last exactly RST_CYCLES cycles and then enter RUN; start SHALL be ignored in this state.
REQ-009 RUN SHALL increment cycle_count by 1 every cycle, including the terminating cycle, without wrap.
REQ-010 RUN PC tracking:
- The first RUN cycle captures pc into pc_prev with the repeat count at 1.
- Each later cycle sets count+1 if pc==pc_prev, else count=1 and pc_prev=pc.
REQ-011 Halt SHALL be detected in the RUN cycle where the repeat count reaches HALT_REPEAT, or, when END_PC_EN=1, where pc==END_PC; the FSM SHALL then enter DONE and halt_pc SHALL load that cycle's pc.
REQ-012 Budget:
- If the MAX_CYCLES-th RUN cycle completes with no halt, the FSM SHALL enter TMO.
- cycle_count SHALL then equal MAX_CYCLES, and halt_pc SHALL load the current pc.
REQ-013 If halt and budget exhaustion occur in the same cycle, DONE SHALL win.
REQ-014 In DONE and TMO, cycle_count and halt_pc SHALL hold.
- clear=1 SHALL enter IDLE.
- Otherwise start=1 SHALL restart exactly as in REQ-007.
- clear SHALL take priority over start.
REQ-015 abort=1 in RST_CORE or RUN SHALL enter IDLE next cycle with cycle_count held; abort SHALL be ignored in other states.
REQ-016 Input priority in RUN SHALL be abort, then halt, then timeout.
REQ-017 start, clear and abort SHALL be level-sampled each cycle; a multi-cycle start SHALL launch only one run because start is ignored outside IDLE, DONE and TMO.

Reset
REQ-018 reset=1 SHALL, at the next rising edge and from any state including mid-RST_CORE and mid-RUN, force:
- state=IDLE, core_reset=1, running=0, done=0, timeout=0;
- cycle_count=0, halt_pc=0, pc_prev=0, repeat count 0, reset counter 0.
REQ-019 reset SHALL take priority over start, clear and abort.

Verification
REQ-020 Defaults; start pulse at edge N -> core_reset=1 for edges N+1..N+4, running=1 from edge N+5.
REQ-021 HALT_REPEAT=3; pc=0,4,8,8,8 in RUN -> done=1 after the 5th RUN cycle, cycle_count=5, halt_pc=8.
REQ-022 MAX_CYCLES=16; pc increments by 4 each cycle -> timeout=1, cycle_count=16, halt_pc=60; then clear -> IDLE with core_reset=1.
REQ-023 MAX_CYCLES=16; third identical pc lands on RUN cycle 16 -> done=1, timeout=0, cycle_count=16.
REQ-024 reset asserted at RUN cycle 7 -> next edge IDLE, cycle_count=0, core_reset=1; abort at RUN cycle 7 -> IDLE with cycle_count=7.
REQ-025 END_PC_EN=1, END_PC=0x20; pc=0x00..0x20 step 4 -> done on 9th cycle, halt_pc=0x20; start+clear together in DONE -> IDLE.
